// File: rtl/sci_tx_pkg.sv
// Shared types and helpers for the SCI transmit path (also used by the future sci_rx).
package sci_tx_pkg;

  localparam int SCI_BIT_TICKS = 32;

  // Serial mode register: CA is carried but unused (async mode only).
  typedef struct packed {
    logic       ca;
    logic       chr;
    logic       pe;
    logic       oe;
    logic       stop;
    logic       mp;
    logic [1:0] cks;
  } smr_t;

  typedef logic [7:0] brr_t;
  typedef logic [7:0] tdr_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    MPB,
    STOP1,
    STOP2
  } sci_tx_state_t;

  // Terminal count of the CKS prescaler: 4^cks - 1.
  function automatic logic [5:0] prescale_max(input logic [1:0] cks);
    case (cks)
      2'd0:    return 6'd0;
      2'd1:    return 6'd3;
      2'd2:    return 6'd15;
      default: return 6'd63;
    endcase
  endfunction

  // Parity over the bits actually sent (7 or 8), inverted for odd parity.
  function automatic logic frame_parity(input tdr_t tdr, input logic chr, input logic oe);
    logic [7:0] bits;
    bits = chr ? {1'b0, tdr[6:0]} : tdr;
    return (^bits) ^ oe;
  endfunction

endpackage

// File: rtl/sci_tx_if.sv
// Register-block <-> transmit-engine signal bundle.
interface sci_tx_if;
  import sci_tx_pkg::*;

  logic ce;
  smr_t smr;
  brr_t brr;
  logic te;
  tdr_t tdr;
  logic tdre;
  logic mpbt;
  logic tdre_set;
  logic tend;
  logic txd;
  logic busy;

  // Register block side.
  modport master (
    output ce, smr, brr, te, tdr, tdre, mpbt,
    input  tdre_set, tend, txd, busy
  );

  // Transmit engine side.
  modport slave (
    input  ce, smr, brr, te, tdr, tdre, mpbt,
    output tdre_set, tend, txd, busy
  );
endinterface

// File: rtl/sci_baud_gen.sv
// Bit-rate generator: 4^CKS prescaler, BRR+1 divider and BIT_TICKS-per-bit counter.
// bit_tick fires on the last CE cycle of each bit period.
module sci_baud_gen
  import sci_tx_pkg::*;
#(
  parameter int BIT_TICKS = SCI_BIT_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       clr,
  input  logic [1:0] cks,
  input  brr_t       brr,
  output logic       bit_tick
);

  localparam int BW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

  logic [5:0]    pre_cnt;
  brr_t          brr_cnt;
  logic [BW-1:0] bit_cnt;
  logic          pre_last;
  logic          brr_last;
  logic          bit_last;

  assign pre_last = (pre_cnt == prescale_max(cks));
  assign brr_last = (brr_cnt == brr);
  assign bit_last = (bit_cnt == BW'(BIT_TICKS - 1));
  assign bit_tick = ce & pre_last & brr_last & bit_last;

  // Cascaded dividers; all wrap to zero together on bit_tick, so bits abut exactly.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      pre_cnt <= '0;
      brr_cnt <= '0;
      bit_cnt <= '0;
    end else if (ce) begin
      if (clr) begin
        pre_cnt <= '0;
        brr_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        pre_cnt <= pre_last ? 6'd0 : pre_cnt + 6'd1;
        if (pre_last)
          brr_cnt <= brr_last ? '0 : brr_cnt + 8'd1;
        if (pre_last && brr_last)
          bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/sci_tx.sv
// SCI asynchronous transmitter: frames TDR onto TXD and reports TDR consumption / TEND.
module sci_tx
  import sci_tx_pkg::*;
#(
  parameter int BIT_TICKS = SCI_BIT_TICKS
) (
  input logic     clk,
  input logic     rst,
  sci_tx_if.slave bus
);

  sci_tx_state_t state;
  tdr_t          shreg;
  logic [2:0]    bit_idx;
  logic          chr_q;
  logic          pe_q;
  logic          mp_q;
  logic          stop_q;
  logic          par_q;
  logic          mpbt_q;
  logic [1:0]    cks_q;
  brr_t          brr_q;

  logic bit_tick;
  logic end_of_frame;
  logic load;
  logic data_last;

  // Frame format and rate are frozen at load; the dividers run from the latched copies.
  sci_baud_gen #(.BIT_TICKS(BIT_TICKS)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .ce       (bus.ce),
    .clr      (load),
    .cks      (cks_q),
    .brr      (brr_q),
    .bit_tick (bit_tick)
  );

  assign end_of_frame = bit_tick && ((state == STOP1 && !stop_q) || state == STOP2);
  assign load         = bus.te && !bus.tdre && (state == IDLE || end_of_frame);
  assign data_last    = (bit_idx == (chr_q ? 3'd6 : 3'd7));

  // Frame FSM with registered TXD/TEND/BUSY/TDRE_SET; everything advances only on CE.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data shifter and latched frame fields are reset too, so a
      // frame abandoned by reset leaves no stale state behind.
      state        <= IDLE;
      shreg        <= '0;
      bit_idx      <= '0;
      chr_q        <= 1'b0;
      pe_q         <= 1'b0;
      mp_q         <= 1'b0;
      stop_q       <= 1'b0;
      par_q        <= 1'b0;
      mpbt_q       <= 1'b0;
      cks_q        <= '0;
      brr_q        <= '0;
      bus.txd      <= 1'b1;
      bus.tend     <= 1'b1;
      bus.tdre_set <= 1'b0;
      bus.busy     <= 1'b0;
    end else if (bus.ce) begin
      bus.tdre_set <= 1'b0;
      if (state != IDLE && !bus.te) begin
        // Transmit disabled mid-frame: abandon immediately, line back to mark.
        state    <= IDLE;
        bus.txd  <= 1'b1;
        bus.tend <= 1'b1;
        bus.busy <= 1'b0;
      end else if (load) begin
        shreg        <= bus.tdr;
        bit_idx      <= '0;
        chr_q        <= bus.smr.chr;
        pe_q         <= bus.smr.pe;
        mp_q         <= bus.smr.mp;
        stop_q       <= bus.smr.stop;
        par_q        <= frame_parity(bus.tdr, bus.smr.chr, bus.smr.oe);
        mpbt_q       <= bus.mpbt;
        cks_q        <= bus.smr.cks;
        brr_q        <= bus.brr;
        state        <= START;
        bus.txd      <= 1'b0;
        bus.tdre_set <= 1'b1;
        bus.tend     <= 1'b0;
        bus.busy     <= 1'b1;
      end else if (bit_tick) begin
        case (state)
          START: begin
            state   <= DATA;
            bus.txd <= shreg[0];
          end
          DATA: begin
            if (data_last) begin
              if (mp_q) begin
                state   <= MPB;
                bus.txd <= mpbt_q;
              end else if (pe_q) begin
                state   <= PARITY;
                bus.txd <= par_q;
              end else begin
                state   <= STOP1;
                bus.txd <= 1'b1;
              end
            end else begin
              shreg   <= shreg >> 1;
              bus.txd <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
          PARITY, MPB: begin
            state   <= STOP1;
            bus.txd <= 1'b1;
          end
          STOP1: begin
            bus.txd <= 1'b1;
            if (stop_q) begin
              state <= STOP2;
            end else begin
              state    <= IDLE;
              bus.tend <= 1'b1;
              bus.busy <= 1'b0;
            end
          end
          STOP2: begin
            state    <= IDLE;
            bus.txd  <= 1'b1;
            bus.tend <= 1'b1;
            bus.busy <= 1'b0;
          end
          default: begin
            bus.txd <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sci_tx.sv
// Self-checking bench for sci_tx: table of single frames plus hand-written corner sequences.
module tb_sci_tx;
  import sci_tx_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   ts_count;

  sci_tx_if bus ();

  sci_tx #(.BIT_TICKS(SCI_BIT_TICKS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  smr;
    logic [7:0]  brr;
    logic [7:0]  tdr;
    logic        mpbt;
    int          nbits;
    int          period;
    logic [11:0] bits;   // bit 0 = start bit, sent first
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at cycle 0 of START; returns at the first cycle after the frame.
  task automatic check_frame(input string name, input logic [11:0] bits,
                             input int nbits, input int p);
    logic tend_seen;
    tend_seen = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      logic seen;
      seen = bits[b];
      for (int c = 0; c < p; c++) begin
        if (bus.txd !== bits[b]) seen = bus.txd;
        if (bus.tend !== 1'b0) tend_seen = 1'b1;
        if (bus.tdre_set === 1'b1) ts_count++;
        tick();
      end
      check($sformatf("%s_bit%0d", name, b), 32'(seen), 32'(bits[b]));
    end
    check({name, "_tend_low"}, 32'(tend_seen), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    bus.smr  = v.smr;
    bus.brr  = v.brr;
    bus.tdr  = v.tdr;
    bus.mpbt = v.mpbt;
    bus.tdre = 1'b0;
    ts_count = 0;
    tick();
    check({v.name, "_load_pulse"}, 32'(bus.tdre_set), 32'd1);
    check({v.name, "_busy"}, 32'(bus.busy), 32'd1);
    // Scramble every latched input; the frame in flight must not change.
    bus.tdre = 1'b1;
    bus.tdr  = ~v.tdr;
    bus.smr  = 8'h3B;
    bus.brr  = 8'h07;
    bus.mpbt = ~v.mpbt;
    check_frame(v.name, v.bits, v.nbits, v.period);
    check({v.name, "_tend_end"}, 32'(bus.tend), 32'd1);
    check({v.name, "_idle_end"}, {bus.busy, bus.txd}, 32'b01);
    check({v.name, "_pulses"}, 32'(ts_count), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ts_count = 0;

    vecs[0] = '{"8N1_55",   8'h00, 8'h00, 8'h55, 1'b0, 10, 32,  12'b00_1_01010101_0};
    vecs[1] = '{"7E2_83",   8'h69, 8'h02, 8'h83, 1'b0, 11, 384, 12'b0_11_0_0000011_0};
    vecs[2] = '{"8O1_01",   8'h30, 8'h00, 8'h01, 1'b0, 11, 32,  12'b0_1_0_00000001_0};
    vecs[3] = '{"MP_A5",    8'h24, 8'h00, 8'hA5, 1'b1, 11, 32,  12'b0_1_1_10100101_0};
    vecs[4] = '{"8N2_F0",   8'h08, 8'h01, 8'hF0, 1'b0, 11, 64,  12'b0_11_11110000_0};
    vecs[5] = '{"7N1_7F",   8'h40, 8'h00, 8'h7F, 1'b0, 9,  32,  12'b000_1_1111111_0};
    vecs[6] = '{"8N1_cks2", 8'h02, 8'h00, 8'h00, 1'b0, 10, 512, 12'b00_1_00000000_0};

    // Reset state.
    rst      = 1'b1;
    bus.ce   = 1'b1;
    bus.smr  = 8'h00;
    bus.brr  = 8'h00;
    bus.te   = 1'b0;
    bus.tdr  = 8'h00;
    bus.tdre = 1'b1;
    bus.mpbt = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {bus.txd, bus.tend, bus.tdre_set, bus.busy}, 32'b1100);
    rst    = 1'b0;
    bus.te = 1'b1;
    repeat (3) tick();
    check("idle_outputs", {bus.txd, bus.tend, bus.tdre_set, bus.busy}, 32'b1100);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back: TDRE cleared again during frame 1.
    bus.smr  = 8'h00;
    bus.brr  = 8'h00;
    bus.tdr  = 8'h55;
    bus.tdre = 1'b0;
    ts_count = 0;
    tick();
    check("b2b_load1", 32'(bus.tdre_set), 32'd1);
    bus.tdr = 8'h0F;
    check_frame("b2b_f1", 12'b00_1_01010101_0, 10, 32);
    check("b2b_load2", {bus.tdre_set, bus.txd, bus.tend, bus.busy}, 32'b1001);
    bus.tdre = 1'b1;
    bus.tdr  = 8'hFF;
    check_frame("b2b_f2", 12'b00_1_00001111_0, 10, 32);
    check("b2b_tend_end", 32'(bus.tend), 32'd1);
    check("b2b_pulses", 32'(ts_count), 32'd2);
    repeat (2) tick();

    // TE abort in mid-DATA (bit 2 of the frame carries data bit 1 = 0).
    bus.tdr  = 8'h55;
    bus.tdre = 1'b0;
    tick();
    bus.tdre = 1'b1;
    repeat (80) tick();
    check("abort_pre_txd", {bus.txd, bus.busy}, 32'b01);
    bus.te = 1'b0;
    tick();
    check("abort_outputs", {bus.txd, bus.busy, bus.tend, bus.tdre_set}, 32'b1010);
    bus.tdre = 1'b0;
    repeat (5) tick();
    check("te0_ignores_tdre", {bus.txd, bus.busy, bus.tend, bus.tdre_set}, 32'b1010);
    bus.te  = 1'b1;
    bus.tdr = 8'h33;
    ts_count = 0;
    tick();
    check("restart_load", {bus.tdre_set, bus.txd}, 32'b10);
    bus.tdre = 1'b1;
    check_frame("restart", 12'b00_1_00110011_0, 10, 32);
    check("restart_tend_end", 32'(bus.tend), 32'd1);
    repeat (2) tick();

    // Reset during the parity bit (8E1, TDR=0x00 -> parity 0).
    bus.smr  = 8'h20;
    bus.tdr  = 8'h00;
    bus.tdre = 1'b0;
    tick();
    bus.tdre = 1'b1;
    repeat (300) tick();
    check("rst_pre_parity", {bus.txd, bus.busy}, 32'b01);
    rst = 1'b1;
    tick();
    check("rst_mid_frame", {bus.txd, bus.tend, bus.tdre_set, bus.busy}, 32'b1100);
    rst = 1'b0;
    repeat (2) tick();

    // CE=0 holds state including the TDRE_SET pulse.
    bus.smr  = 8'h00;
    bus.tdr  = 8'h55;
    bus.tdre = 1'b0;
    tick();
    bus.tdre = 1'b1;
    bus.ce   = 1'b0;
    repeat (4) tick();
    check("ce0_hold", {bus.tdre_set, bus.txd, bus.busy}, 32'b101);
    bus.ce = 1'b1;
    tick();
    check("ce1_pulse_drop", {bus.tdre_set, bus.txd}, 32'b00);
    bus.te = 1'b0;
    tick();
    check("ce_abort", {bus.busy, bus.txd, bus.tend}, 32'b011);
    bus.te = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sci_tx.md
Name: sci_tx

Overview:
- Asynchronous transmit engine of the on-chip SCI.
- Serialises TDR onto TXD using the frame format from SMR and the bit rate from SMR.CKS/BRR.
- Reports TDR consumption and transmit-end status back to the SCI register block, which owns SSR and raises TXI/TEI.
- Sits between the SCI register file and the TXD pin. It is the transmit counterpart to the future sci_rx.

Parameters:
- BIT_TICKS, 32, baud-generator ticks per transmitted bit (async mode: 32·4^CKS·(BRR+1) clocks per bit).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CE  in  1  clock enable; all state advances only when CE=1
- SMR  in  8  SMR_t: CHR, PE, OE, STOP, MP, CKS (CA ignored, async only)
- BRR  in  8  bit-rate register
- TE  in  1  SCR.TE
- TDR  in  8  transmit data register
- TDRE  in  1  current SSR.TDRE (0 = new data pending)
- MPBT  in  1  SSR.MPBT, multiprocessor bit value
- TDRE_SET  out  1  one-CE-cycle pulse when TDR is loaded into the shifter
- TEND  out  1  transmit-end flag (level)
- TXD  out  1  serial output, idle high
- BUSY  out  1  1 when the FSM is not in IDLE

Behaviour:
- **Reset.** TXD=1, TEND=1, TDRE_SET=0, BUSY=0, FSM in IDLE, counters cleared. This matches SSR_INIT 0x84.
- **Baud generator.**
  - Prescaler ticks every 4^CKS CE cycles. BRR counter divides that by BRR+1, giving the baud tick.
  - Bit counter counts BIT_TICKS baud ticks per bit. One bit period P = 32·4^CKS·(BRR+1) CE cycles.
  - All dividers are cleared on frame load, so the start bit is exactly P long.
- **Load.**
  - Condition: in IDLE with TE=1 and TDRE=0 on CE cycle N.
  - At N+1 the FSM enters START, TXD=0, TDRE_SET=1 (that cycle only) and TEND=0.
  - TDR, CHR, PE, OE, STOP, MP, MPBT, CKS and BRR are latched at load. Changes to these inputs mid-frame do not affect the current frame.
- **FSM.**
  - IDLE -> START -> DATA -> [PARITY | MPB] -> STOP1 -> [STOP2] -> IDLE or START.
  - Each non-IDLE state lasts exactly P.
  - DATA shifts LSB first: 8 bits if CHR=0, 7 bits (TDR[6:0]) if CHR=1.
  - MP=1 selects the MPB state (TXD=latched MPBT), and PE is ignored.
  - MP=0 with PE=1 selects PARITY. Bit = XOR of transmitted data bits, inverted when OE=1 (odd parity).
  - STOP2 is present only when STOP=1. Stop bits drive TXD=1.
- **End of last stop bit.**
  - If TE=1 and TDRE=0: go directly to START (no idle gap) with a fresh TDRE_SET pulse.
  - Otherwise: go to IDLE and set TEND=1.
- **TE=0 while BUSY.** Abort immediately on the next CE cycle: TXD=1, FSM to IDLE, TEND=1, no TDRE_SET.
- **TE=0 in IDLE.** TXD held 1. TDRE=0 is ignored until TE=1.
- **RST mid-frame.** Identical to the reset values above. A partial frame is abandoned with TXD=1.
- **CE=0.** All state and outputs hold, including a TDRE_SET pulse, which is held high until the next CE cycle.

Decomposition:
- CPU_PKG additions:
  - enum sci_tx_state_t {IDLE, START, DATA, PARITY, MPB, STOP1, STOP2}.
  - SCI_BIT_TICKS = 32.
  - Reuse SMR_t, BRR_t, TDR_t, SCR_t for inputs.
- Sub-module sci_baud_gen: CKS prescaler, BRR divider, BIT_TICKS counter, sync clear input, bit-tick output. It will be shared with sci_rx.

Test Plan:
- **8N1 at P=32.** CKS=0, BRR=0, SMR=0x00, TE=1, TDR=0x55, TDRE 1->0 -> TDRE_SET pulses once. TXD reads 0,1,0,1,0,1,0,1,0,1, each level exactly 32 cycles. TEND rises at cycle 320 after load.
- **7E2 at P=384.** CKS=1, BRR=2, CHR=1, PE=1, OE=0, STOP=1, TDR=0x83 -> TXD reads start 0; data 1,1,0,0,0,0,0; parity 0; stop 1,1. Total 11 bits = 4224 cycles.
- **Odd parity and MP mode.** 8O1 with TDR=0x01 gives parity 0. MP=1, PE=1, MPBT=1 gives no parity bit and MPB=1 before stop. Frame length 11·P.
- **Back-to-back.** Clear TDRE again during frame 1 -> the start of frame 2 immediately follows the stop of frame 1 with no gap. Two TDRE_SET pulses. TEND stays 0 until the end of frame 2.
- **TE abort.** TE drops at mid-DATA -> the next CE cycle has TXD=1, BUSY=0, TEND=1. TE back to 1 with TDRE=0 starts a new full frame.
- **RST mid-frame.** Assert RST during PARITY -> the next cycle has TXD=1, TEND=1, TDRE_SET=0, BUSY=0.
